// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 receive decoder.
package ws2812_pkg;

    localparam int unsigned PIXEL_BITS = 24;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_e;

    localparam logic [1:0] ERR_LONG_HIGH = 2'b01;
    localparam logic [1:0] ERR_PARTIAL   = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Line synchronizer and edge detector for the WS2812 receiver.
// WS2812_RX_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 cycles latency).
module ws2812_rx_sync
    import ws2812_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic data_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= data_i;
            s2_q <= s1_q;
        end
    end

`ifdef WS2812_RX_GLITCH_FILTER_EN
    logic m1_q;
    logic m2_q;
    logic filt_q;

    // Both edges are delayed equally, so measured pulse widths are preserved.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            m1_q   <= s2_q;
            m2_q   <= m1_q;
            filt_q <= maj3(s2_q, m1_q, m2_q);
        end
    end

    assign level = filt_q;
`else
    assign level = s2_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receive decoder: pulse-width bit recovery, GRB pixel assembly, latch-gap framing.
// Optional WS2812_RX_GLITCH_FILTER_EN enables spike rejection inside ws2812_rx_sync.
module ws2812_rx_decoder
    import ws2812_pkg::*;
#(
    parameter int unsigned BIT_THRESH = 38,
    parameter int unsigned HIGH_MAX   = 64,
    parameter int unsigned RESET_CYC  = 3200,
    parameter int unsigned IDX_W      = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  ws2812_data_in,
    output logic [23:0]           pixel_data_out,
    output logic [IDX_W-1:0]      pixel_idx_out,
    output logic                  pixel_valid_out,
    output logic                  frame_done_out,
    output logic [IDX_W:0]        frame_len_out,
    output logic                  err_out,
    output logic [1:0]            err_code_out
);

    localparam int unsigned CNT_W = $clog2(RESET_CYC + 1);
    localparam int unsigned BIT_W = $clog2(PIXEL_BITS);

    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] HMAX_C     = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(RESET_CYC - 1);
    localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(PIXEL_BITS - 1);

    logic level;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .data_i  (ws2812_data_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    rx_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc_d;
    logic [PIXEL_BITS-1:0] shift_q;
    logic [PIXEL_BITS-1:0] pixel_d;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [IDX_W:0]        pix_cnt_q;
    logic                  ovf_q;
    logic                  last_bit_d;

    logic [23:0]           pixel_data_q;
    logic [IDX_W-1:0]      pixel_idx_q;
    logic                  pixel_valid_q;
    logic                  frame_done_q;
    logic [IDX_W:0]        frame_len_q;
    logic                  err_q;
    logic [1:0]            err_code_q;

    always_comb begin
        cnt_inc_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        pixel_d    = {shift_q[PIXEL_BITS-2:0], (cnt_q >= THRESH_C)};
        last_bit_d = (bit_cnt_q == LAST_BIT_C);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_SYNC;
            cnt_q         <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            pixel_data_q  <= '0;
            pixel_idx_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;

            case (state_q)
                ST_SYNC: begin
                    if (level) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= GAP_LAST_C) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                ST_IDLE: begin
                    if (rise) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (cnt_q > HMAX_C) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_LONG_HIGH;
                        bit_cnt_q  <= '0;
                        pix_cnt_q  <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_SYNC;
                    end else if (fall) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_LOW;
                        shift_q <= pixel_d;
                        if (last_bit_d) begin
                            bit_cnt_q <= '0;
                            // pix_cnt_q stops at 2**IDX_W, which doubles as the overflow marker.
                            if (!pix_cnt_q[IDX_W]) begin
                                pixel_valid_q <= 1'b1;
                                pixel_data_q  <= pixel_d;
                                pixel_idx_q   <= pix_cnt_q[IDX_W-1:0];
                                pix_cnt_q     <= pix_cnt_q + 1'b1;
                            end else if (!ovf_q) begin
                                ovf_q      <= 1'b1;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_OVERFLOW;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_HIGH;
                    end else if (cnt_q >= GAP_LAST_C) begin
                        frame_done_q <= 1'b1;
                        frame_len_q  <= pix_cnt_q;
                        if (bit_cnt_q != '0) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_PARTIAL;
                        end
                        bit_cnt_q <= '0;
                        pix_cnt_q <= '0;
                        ovf_q     <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign pixel_data_out  = pixel_data_q;
    assign pixel_idx_out   = pixel_idx_q;
    assign pixel_valid_out = pixel_valid_q;
    assign frame_done_out  = frame_done_q;
    assign frame_len_out   = frame_len_q;
    assign err_out         = err_q;
    assign err_code_out    = err_code_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed self-checking bench for ws2812_rx_decoder (small frame, short gap for run time).
module tb_ws2812_rx_decoder;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned GAP   = 700;
`ifdef WS2812_RX_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             din = 1'b0;
    logic [23:0]      pixel_data_out;
    logic [IDX_W-1:0] pixel_idx_out;
    logic             pixel_valid_out;
    logic             frame_done_out;
    logic [IDX_W:0]   frame_len_out;
    logic             err_out;
    logic [1:0]       err_code_out;

    ws2812_rx_decoder #(
        .BIT_THRESH (38),
        .HIGH_MAX   (64),
        .RESET_CYC  (600),
        .IDX_W      (IDX_W)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .ws2812_data_in  (din),
        .pixel_data_out  (pixel_data_out),
        .pixel_idx_out   (pixel_idx_out),
        .pixel_valid_out (pixel_valid_out),
        .frame_done_out  (frame_done_out),
        .frame_len_out   (frame_len_out),
        .err_out         (err_out),
        .err_code_out    (err_code_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Event monitor: records every strobe seen on the falling clock edge.
    int          cyc = 0;
    int          pv_n = 0;
    int          fd_n = 0;
    int          er_n = 0;
    int          fd_cyc = 0;
    int          er_cyc = 0;
    logic [23:0] pv_data [64];
    logic [2:0]  pv_idx [64];
    logic [3:0]  fd_len = '0;
    logic [1:0]  er_code = '0;

    always @(negedge clk_in) begin
        cyc++;
        if (pixel_valid_out) begin
            if (pv_n < 64) begin
                pv_data[pv_n] = pixel_data_out;
                pv_idx[pv_n]  = pixel_idx_out;
            end
            pv_n++;
        end
        if (frame_done_out) begin
            fd_len = frame_len_out;
            fd_cyc = cyc;
            fd_n++;
        end
        if (err_out) begin
            er_code = err_code_out;
            er_cyc  = cyc;
            er_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int hi;
        hi = b ? 48 : 19;
        din = 1'b1;
        repeat (hi) @(negedge clk_in);
        din = 1'b0;
        repeat (80 - hi) @(negedge clk_in);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    typedef struct {
        logic [23:0] pix;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs [8];

    int          pb, fb, eb, lat;
    logic [23:0] p;
    logic [23:0] exp_pix;

    initial begin
        vecs[0] = '{24'hFF0055, 3'd0};
        vecs[1] = '{24'h000000, 3'd1};
        vecs[2] = '{24'hFFFFFF, 3'd2};
        vecs[3] = '{24'h800001, 3'd3};
        vecs[4] = '{24'h123456, 3'd4};
        vecs[5] = '{24'hA5A5A5, 3'd5};
        vecs[6] = '{24'h0F0F0F, 3'd6};
        vecs[7] = '{24'h7E7E81, 3'd7};

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("reset_outputs", 32'({pixel_data_out, pixel_idx_out, pixel_valid_out,
                                  frame_done_out, frame_len_out, err_out, err_code_out}), 32'd0);
        rst_n_in = 1'b1;

        // T1: single pixel, pin-to-strobe latency, frame length 1
        gap(GAP);
        pb = pv_n; fb = fd_n; eb = er_n; lat = 0;
        p = 24'hFF0055;
        for (int i = 23; i >= 1; i--) send_bit(p[i]);
        din = 1'b1;
        repeat (48) @(negedge clk_in);
        din = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            if (pixel_valid_out && lat == 0) lat = k;
        end
        gap(GAP - 10);
        chk("t1_latency", 32'(lat), 32'(LAT));
        chk("t1_count", 32'(pv_n - pb), 32'd1);
        chk("t1_data", 32'(pv_data[pb]), 32'hFF0055);
        chk("t1_idx", 32'(pv_idx[pb]), 32'd0);
        chk("t1_done", 32'(fd_n - fb), 32'd1);
        chk("t1_len", 32'(fd_len), 32'd1);
        chk("t1_noerr", 32'(er_n - eb), 32'd0);

        // T2: full frame from the vector table
        pb = pv_n; fb = fd_n; eb = er_n;
        for (int i = 0; i < 8; i++) send_pixel(vecs[i].pix);
        gap(GAP);
        chk("t2_count", 32'(pv_n - pb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", 32'(pv_data[pb + i]), 32'(vecs[i].pix));
            chk("t2_idx", 32'(pv_idx[pb + i]), 32'(vecs[i].exp_idx));
        end
        chk("t2_done", 32'(fd_n - fb), 32'd1);
        chk("t2_len", 32'(fd_len), 32'd8);
        chk("t2_noerr", 32'(er_n - eb), 32'd0);

        // T3: one pixel beyond capacity
        pb = pv_n; fb = fd_n; eb = er_n;
        for (int i = 0; i < 8; i++) send_pixel(vecs[i].pix);
        send_pixel(24'h0000FF);
        gap(GAP);
        chk("t3_count", 32'(pv_n - pb), 32'd8);
        chk("t3_last_idx", 32'(pv_idx[pb + 7]), 32'd7);
        chk("t3_err_n", 32'(er_n - eb), 32'd1);
        chk("t3_err_code", 32'(er_code), 32'd3);
        chk("t3_len", 32'(fd_len), 32'd8);

        // T4: partial pixel at the gap
        pb = pv_n; fb = fd_n; eb = er_n;
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        gap(GAP);
        chk("t4_count", 32'(pv_n - pb), 32'd0);
        chk("t4_done", 32'(fd_n - fb), 32'd1);
        chk("t4_len", 32'(fd_len), 32'd0);
        chk("t4_err_code", 32'(er_code), 32'd2);
        chk("t4_same_cycle", 32'(er_cyc), 32'(fd_cyc));

        // T5: over-long high, resync, recovery
        pb = pv_n; fb = fd_n; eb = er_n;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        din = 1'b1;
        repeat (70) @(negedge clk_in);
        gap(100);
        send_pixel(24'hFFFFFF);
        gap(GAP);
        chk("t5_err_n", 32'(er_n - eb), 32'd1);
        chk("t5_err_code", 32'(er_code), 32'd1);
        chk("t5_ignored", 32'(pv_n - pb), 32'd0);
        chk("t5_no_done", 32'(fd_n - fb), 32'd0);
        send_pixel(24'h123456);
        gap(GAP);
        chk("t5_count", 32'(pv_n - pb), 32'd1);
        chk("t5_data", 32'(pv_data[pb]), 32'h123456);
        chk("t5_idx", 32'(pv_idx[pb]), 32'd0);
        chk("t5_len", 32'(fd_len), 32'd1);

        // T6: single-cycle spike in the low phase of the first bit
        pb = pv_n; fb = fd_n; eb = er_n;
        p = 24'hA5A5A5;
        din = 1'b1;
        repeat (48) @(negedge clk_in);
        din = 1'b0;
        repeat (10) @(negedge clk_in);
        din = 1'b1;
        @(negedge clk_in);
        din = 1'b0;
        repeat (21) @(negedge clk_in);
        for (int i = 22; i >= 0; i--) send_bit(p[i]);
        gap(GAP);
`ifdef WS2812_RX_GLITCH_FILTER_EN
        exp_pix = p;
        chk("t6_err_n", 32'(er_n - eb), 32'd0);
`else
        exp_pix = {2'b10, p[22:1]};
        chk("t6_err_n", 32'(er_n - eb), 32'd1);
        chk("t6_err_code", 32'(er_code), 32'd2);
`endif
        chk("t6_count", 32'(pv_n - pb), 32'd1);
        chk("t6_data", 32'(pv_data[pb]), 32'(exp_pix));
        chk("t6_len", 32'(fd_len), 32'd1);

        // T7: reset mid-pixel, then nothing decodes until a gap resynchronises
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        rst_n_in = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("t7_reset_outputs", 32'({pixel_data_out, pixel_idx_out, pixel_valid_out,
                                     frame_done_out, frame_len_out, err_out, err_code_out}), 32'd0);
        rst_n_in = 1'b1;
        pb = pv_n; fb = fd_n; eb = er_n;
        send_pixel(24'hFFFFFF);
        gap(GAP);
        chk("t7_no_strobe", 32'(pv_n - pb), 32'd0);
        chk("t7_no_done", 32'(fd_n - fb), 32'd0);
        chk("t7_no_err", 32'(er_n - eb), 32'd0);
        send_pixel(24'h00FF00);
        gap(GAP);
        chk("t7_count", 32'(pv_n - pb), 32'd1);
        chk("t7_data", 32'(pv_data[pb]), 32'h00FF00);
        chk("t7_idx", 32'(pv_idx[pb]), 32'd0);
        chk("t7_len", 32'(fd_len), 32'd1);

        repeat (5) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
